// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with frame-aligned run/stop
// and a PIPE_DLY-stage sync/DE delay line for fixed-latency pixel sources.
`default_nettype none

module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int ADDR_W   = 11,
  parameter int PIPE_DLY = 0
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [ADDR_W-1:0] x,
  output logic [ADDR_W-1:0] y,
  output logic              pix_req,
  output logic              line_start,
  output logic              frame_start,
  output logic              busy
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(H_TOTAL - 1);
  localparam logic [ADDR_W-1:0] V_LAST = ADDR_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] H_SW   = ADDR_W'(H_SYNC);
  localparam logic [ADDR_W-1:0] V_SW   = ADDR_W'(V_SYNC);
  localparam logic [ADDR_W-1:0] H_VS   = ADDR_W'(H_SYNC + H_BACK);
  localparam logic [ADDR_W-1:0] V_VS   = ADDR_W'(V_SYNC + V_BACK);
  localparam logic [ADDR_W-1:0] H_VE   = ADDR_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_VE   = ADDR_W'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic              HS_ACT = (HS_POL != 0);
  localparam logic              VS_ACT = (VS_POL != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] h_cnt, v_cnt;
  logic              frame_end, counting, vis;
  logic              hs0, vs0, de0;

  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign counting  = (state != S_IDLE);
  assign vis       = counting && (h_cnt >= H_VS) && (h_cnt < H_VE)
                              && (v_cnt >= V_VS) && (v_cnt < V_VE);

  // Stopping is only ever allowed on the last pixel of a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN:   if (!en) state_nxt = frame_end ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (en)             state_nxt = S_RUN;
        else if (frame_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!counting) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ADDR_W'(1);
    end else begin
      h_cnt <= h_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      pix_req     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs0         <= ~HS_ACT;
      vs0         <= ~VS_ACT;
      de0         <= 1'b0;
    end else begin
      x           <= vis ? h_cnt - H_VS : '0;
      y           <= vis ? v_cnt - V_VS : '0;
      pix_req     <= vis;
      line_start  <= vis && (h_cnt == H_VS);
      frame_start <= vis && (h_cnt == H_VS) && (v_cnt == V_VS);
      hs0         <= (counting && (h_cnt < H_SW)) ? HS_ACT : ~HS_ACT;
      vs0         <= (counting && (v_cnt < V_SW)) ? VS_ACT : ~VS_ACT;
      de0         <= vis;
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign hsync = hs0;
      assign vsync = vs0;
      assign de    = de0;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_sr, vs_sr, de_sr;

      always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
          hs_sr <= {PIPE_DLY{~HS_ACT}};
          vs_sr <= {PIPE_DLY{~VS_ACT}};
          de_sr <= '0;
        end else begin
          hs_sr <= PIPE_DLY'({hs_sr, hs0});
          vs_sr <= PIPE_DLY'({vs_sr, vs0});
          de_sr <= PIPE_DLY'({de_sr, de0});
        end
      end

      assign hsync = hs_sr[PIPE_DLY-1];
      assign vsync = vs_sr[PIPE_DLY-1];
      assign de    = de_sr[PIPE_DLY-1];
    end
  endgenerate

endmodule

`default_nettype wire
